// File: rtl/sing_io_xcvr.sv
// sing_io_xcvr
// Half-duplex single-wire byte transceiver driving a pin tristate buffer.
// Frames are UART style: start bit (0), 8 data bits LSB first, stop bit (1).
//
// Ports:
//   clk, rst_n            system clock (rising edge), async active-low reset
//   tx_data/tx_valid      byte to send, accepted when tx_ready is high
//   tx_ready              idle, line high and out of reset
//   rx_data               last good received byte (held)
//   rx_valid              1-cycle pulse, rx_data updated
//   rx_frame_err          1-cycle pulse, stop bit sampled low
//   busy                  transceiver not idle
//   io_i / io_t           buffer data / tristate enable (io_t=1 releases pin)
//   io_o                  pad readback from the buffer
module sing_io_xcvr #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       busy,
  output logic       io_i,
  output logic       io_t,
  input  logic       io_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [3:0] {
    IDLE, TX_START, TX_DATA, TX_STOP, TX_GUARD,
    RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      bit_reg, bit_next;
  logic [7:0]      tx_shift_reg, tx_shift_next;
  logic [7:0]      rx_shift_reg, rx_shift_next;
  logic [7:0]      rx_data_reg, rx_data_next;
  logic            rx_valid_reg, rx_valid_next;
  logic            rx_frame_err_reg, rx_frame_err_next;
  logic            io_i_reg, io_i_next;
  logic            io_t_reg, io_t_next;
  logic [1:0]      sync_reg;
  logic            s_d_reg;
  logic            run_reg;
  logic            s, fall, cnt_done;

  assign s        = sync_reg[1];
  assign fall     = s_d_reg & ~s;
  assign cnt_done = (cnt_reg == CNT_LAST);

  // run_reg keeps tx_ready low while reset is held and on the first edge
  // after release, so no byte is taken on the reset-release edge.
  assign tx_ready     = (state_reg == IDLE) & s & run_reg;
  assign busy         = (state_reg != IDLE);
  assign rx_data      = rx_data_reg;
  assign rx_valid     = rx_valid_reg;
  assign rx_frame_err = rx_frame_err_reg;
  assign io_i         = io_i_reg;
  assign io_t         = io_t_reg;

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_done ? '0 : cnt_reg + 1'b1;
    bit_next          = bit_reg;
    tx_shift_next     = tx_shift_reg;
    rx_shift_next     = rx_shift_reg;
    rx_data_next      = rx_data_reg;
    rx_valid_next     = 1'b0;
    rx_frame_err_next = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (tx_valid && tx_ready) begin
          tx_shift_next = tx_data;
          state_next    = TX_START;
        end else if (fall) begin
          state_next = RX_START;
        end
      end
      TX_START: if (cnt_done) begin
        bit_next   = 3'd0;
        state_next = TX_DATA;
      end
      TX_DATA: if (cnt_done) begin
        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
        bit_next      = bit_reg + 3'd1;
        if (bit_reg == 3'd7) state_next = TX_STOP;
      end
      TX_STOP:  if (cnt_done) state_next = TX_GUARD;
      TX_GUARD: if (cnt_done) state_next = IDLE;
      RX_START: if (cnt_reg == CNT_MID) begin
        // Mid start-bit check: a line already back high was a glitch.
        cnt_next   = '0;
        bit_next   = 3'd0;
        state_next = s ? IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_done) begin
        rx_shift_next = {s, rx_shift_reg[7:1]};
        bit_next      = bit_reg + 3'd1;
        if (bit_reg == 3'd7) state_next = RX_STOP;
      end
      RX_STOP: if (cnt_done) begin
        if (s) begin
          rx_data_next  = rx_shift_reg;
          rx_valid_next = 1'b1;
          state_next    = IDLE;
        end else begin
          rx_frame_err_next = 1'b1;
          state_next        = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        cnt_next = '0;
        if (s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Pin drive is registered from the next state so the pad sees clean
    // edges aligned to the state change.
    io_t_next = !(state_next inside {TX_START, TX_DATA, TX_STOP});
    if (state_next == TX_START)     io_i_next = 1'b0;
    else if (state_next == TX_DATA) io_i_next = tx_shift_next[0];
    else                            io_i_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      bit_reg          <= '0;
      tx_shift_reg     <= '0;
      rx_shift_reg     <= '0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      rx_frame_err_reg <= 1'b0;
      io_i_reg         <= 1'b1;
      io_t_reg         <= 1'b1;
      sync_reg         <= 2'b11;
      s_d_reg          <= 1'b1;
      run_reg          <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      bit_reg          <= bit_next;
      tx_shift_reg     <= tx_shift_next;
      rx_shift_reg     <= rx_shift_next;
      rx_data_reg      <= rx_data_next;
      rx_valid_reg     <= rx_valid_next;
      rx_frame_err_reg <= rx_frame_err_next;
      io_i_reg         <= io_i_next;
      io_t_reg         <= io_t_next;
      sync_reg         <= {sync_reg[0], io_o};
      s_d_reg          <= s;
      run_reg          <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sing_io_xcvr.sv
// Testbench for sing_io_xcvr: IOBUF pad model, random TX/RX frames checked
// against frame-level expectations.
module tb_sing_io_xcvr;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       busy;
  logic       io_i;
  logic       io_t;
  logic       ext_line = 1'b1;   // remote driver / pull-up when released
  wire        io_o;

  // Pad: our driver wins while enabled, otherwise the external line.
  assign io_o = io_t ? ext_line : io_i;

  sing_io_xcvr #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
    .busy(busy), .io_i(io_i), .io_t(io_t), .io_o(io_o)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail = 0;
  int         n_rx_valid = 0;
  int         n_rx_err = 0;
  logic [7:0] exp_rx_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) n_rx_valid++;
      if (rx_frame_err) n_rx_err++;
      if (rx_valid | rx_frame_err) check("rx_excl", 32'(rx_valid & rx_frame_err), 0);
    end
  end

  // Frame bit idx: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic frame_bit(input logic [7:0] b, input int idx, input logic stop);
    if (idx == 0) return 1'b0;
    if (idx == 9) return stop;
    return b[idx-1];
  endfunction

  // Transmit one byte. hold keeps tx_valid high for a back-to-back send;
  // cont means we are already in the IDLE cycle after a previous hold.
  task automatic do_tx(input logic [7:0] b, input bit hold, input bit cont);
    int v0 = n_rx_valid;
    int e0 = n_rx_err;
    if (!cont) begin
      @(negedge clk);
      check("tx_ready_idle", 32'(tx_ready), 1);
    end
    tx_data  = b;
    tx_valid = 1'b1;
    for (int k = 1; k <= 10*CPB; k++) begin
      @(negedge clk);
      if (!hold) tx_valid = 1'b0;
      check("tx_io_t", 32'(io_t), 0);
      check("tx_io_i", 32'(io_i), 32'(frame_bit(b, (k-1)/CPB, 1'b1)));
      check("tx_busy", 32'(busy), 1);
    end
    for (int k = 0; k < CPB; k++) begin
      @(negedge clk);
      check("guard_io_t", 32'(io_t), 1);
      check("guard_tx_ready", 32'(tx_ready), 0);
    end
    @(negedge clk);
    check("tx_ready_after", 32'(tx_ready), 1);
    check("tx_echo_valid", 32'(n_rx_valid - v0), 0);
    check("tx_echo_err", 32'(n_rx_err - e0), 0);
    $display("[TB] tx byte 0x%02h hold=%0d", b, hold);
  endtask

  // Receive one frame driven on the external line.
  task automatic do_rx(input logic [7:0] b, input logic stop);
    int v0 = n_rx_valid;
    int e0 = n_rx_err;
    int k;
    for (int i = 0; i < 10; i++) begin
      ext_line = frame_bit(b, i, stop);
      repeat (CPB) begin
        @(negedge clk);
        check("rx_io_t", 32'(io_t), 1);
      end
    end
    if (stop) begin
      ext_line = 1'b1;
      repeat (3*CPB) begin
        @(negedge clk);
        check("rx_io_t", 32'(io_t), 1);
      end
      exp_rx_data = b;
      check("rx_valid_cnt", 32'(n_rx_valid - v0), 1);
      check("rx_err_cnt", 32'(n_rx_err - e0), 0);
      check("rx_data", 32'(rx_data), 32'(exp_rx_data));
    end else begin
      repeat (20) begin
        @(negedge clk);
        check("break_tx_ready", 32'(tx_ready), 0);
      end
      ext_line = 1'b1;
      k = 0;
      while (!tx_ready && k < 8) begin
        @(negedge clk);
        k++;
      end
      check("break_recover", 32'(tx_ready), 1);
      check("ferr_cnt", 32'(n_rx_err - e0), 1);
      check("ferr_valid_cnt", 32'(n_rx_valid - v0), 0);
      check("ferr_rx_data", 32'(rx_data), 32'(exp_rx_data));
    end
    $display("[TB] rx byte 0x%02h stop=%0d", b, stop);
  endtask

  initial begin
    int v0, e0, k;
    logic [7:0] r;

    // 1. Reset state with tx_valid asserted.
    tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_io_t", 32'(io_t), 1);
    check("rst_io_i", 32'(io_i), 1);
    check("rst_tx_ready", 32'(tx_ready), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tx_valid = 1'b0;
    @(negedge clk);
    check("rel_tx_ready", 32'(tx_ready), 1);
    check("rel_rx_data", 32'(rx_data), 0);
    $display("[TB] reset released");

    // 2. TX 0xA5 held valid, then back-to-back random byte.
    do_tx(8'hA5, 1'b1, 1'b0);
    do_tx(8'($urandom), 1'b0, 1'b1);

    // 3. RX 0x3C.
    repeat (2) @(negedge clk);
    do_rx(8'h3C, 1'b1);

    // 4. Frame error with break.
    do_rx(8'h55, 1'b0);

    // 5. One-cycle glitch.
    v0 = n_rx_valid;
    e0 = n_rx_err;
    @(negedge clk);
    ext_line = 1'b0;
    @(negedge clk);
    ext_line = 1'b1;
    k = 0;
    while (!tx_ready && k < 6) begin
      @(negedge clk);
      k++;
    end
    check("glitch_ready", 32'(tx_ready), 1);
    check("glitch_busy", 32'(busy), 0);
    repeat (4) @(negedge clk);
    check("glitch_valid", 32'(n_rx_valid - v0), 0);
    check("glitch_err", 32'(n_rx_err - e0), 0);
    $display("[TB] glitch done");

    // 6. Reset during a data bit.
    @(negedge clk);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_io_t", 32'(io_t), 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_io_t", 32'(io_t), 1);
    check("async_rst_io_i", 32'(io_i), 1);
    check("async_rst_busy", 32'(busy), 0);
    @(negedge clk);
    check("async_rst_valid", 32'(rx_valid), 0);
    exp_rx_data = 8'h00;
    check("async_rst_rx_data", 32'(rx_data), 0);
    rst_n = 1'b1;
    do_tx(8'hFF, 1'b0, 1'b0);

    // Randomized traffic in both directions.
    for (int i = 0; i < 6; i++) begin
      r = 8'($urandom);
      case ($urandom_range(2))
        0: do_tx(r, 1'b0, 1'b0);
        1: do_rx(r, 1'b1);
        default: do_rx(r, 1'b0);
      endcase
      repeat ($urandom_range(3)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
